mod_updown_counter: RTL

Parametrised up/down counter, successor to the fixed 4-bit free-running counter. Adds configurable width and modulus, direction control, parallel load, synchronous clear, clock-enable with a built-in prescaler, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Used as the general timebase and event-counting primitive in the playground designs.

---
 rtl/mod_updown_counter.sv | 71 +++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with prescaled enable, parallel load, synchronous clear,
// wrap or saturate at the limits, a terminal-count pulse and a sticky overflow flag.
module mod_updown_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter bit SATURATE  = 1'b0,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre;
    logic             step;
    logic             at_limit;
    logic             limit_step;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_clamped;

    assign step         = en && (pre == PRE_LAST);
    assign at_limit     = up ? (count == MAX_V) : (count == '0);
    assign limit_step   = step && at_limit && !clr && !load;
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

    // Limit is tested before the +/-1 so the result never needs a carry bit.
    always_comb begin
        step_val = count;
        if (at_limit)
            step_val = SATURATE ? count : (up ? '0 : MAX_V);
        else
            step_val = up ? count + WIDTH'(1) : count - WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            pre   <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            tc  <= limit_step;
            // A limit step on the same edge as ovf_clr keeps the flag set.
            ovf <= limit_step | (ovf & ~ovf_clr);
            if (clr) begin
                count <= '0;
                pre   <= '0;
            end else if (load) begin
                count <= load_clamped;
                pre   <= '0;
            end else if (en) begin
                pre <= step ? '0 : pre + PW'(1);
                if (step)
                    count <= step_val;
            end
        end
    end

endmodule
